// File: rtl/ssd_scan_scheduler_pkg.sv
// Shared constants and helpers for the seven-segment scan scheduler:
// anode patterns, source ids and round-robin source search.
package ssd_scan_scheduler_pkg;

    typedef logic [1:0] idx_t;
    typedef logic [1:0] src_t;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b0111;
    localparam logic [3:0] AN_D1  = 4'b1011;
    localparam logic [3:0] AN_D2  = 4'b1101;
    localparam logic [3:0] AN_D3  = 4'b1110;

    localparam src_t SRC_PC  = 2'd0;
    localparam src_t SRC_REG = 2'd1;
    localparam src_t SRC_ALU = 2'd2;
    localparam src_t SRC_AUX = 2'd3;

    // First valid source strictly after cur, wrapping; returns cur when none other is valid.
    function automatic src_t next_valid(input src_t cur, input logic [3:0] valid);
        src_t r;
        src_t c;
        r = cur;
        for (int k = 3; k >= 1; k--) begin
            c = cur + src_t'(k);
            if (valid[c]) r = c;
        end
        return r;
    endfunction

    function automatic logic [3:0] digit_nibble(input logic [15:0] snap, input idx_t idx);
        logic [3:0] n;
        case (idx)
            2'd0:    n = snap[15:12];
            2'd1:    n = snap[11:8];
            2'd2:    n = snap[7:4];
            default: n = snap[3:0];
        endcase
        return n;
    endfunction

    function automatic logic [3:0] anode_pattern(input idx_t idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = AN_D0;
            2'd1:    a = AN_D1;
            2'd2:    a = AN_D2;
            default: a = AN_D3;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ssd_scan_timer.sv
// Slot/digit scan timing: slot counter, digit index, blank-phase flag and
// a registered frame_start pulse on the first cycle of digit 0.
module ssd_scan_timer
    import ssd_scan_scheduler_pkg::*;
#(
    parameter int SCAN_DIV     = 200000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic i_clock,
    input  logic i_reset,
    output idx_t o_idx,
    output logic o_boundary,
    output logic o_blank,
    output logic o_frame_start
);

    localparam int             SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]  BLANK_END = SW'(BLANK_CYCLES);

    logic [SW-1:0] r_slot;
    idx_t          r_idx;
    logic          r_frame_start;

    assign o_idx         = r_idx;
    assign o_boundary    = (r_slot == '0) && (r_idx == 2'd0);
    assign o_blank       = (r_slot < BLANK_END);
    assign o_frame_start = r_frame_start;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_slot        <= '0;
            r_idx         <= 2'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= o_boundary;
            if (r_slot == SLOT_LAST) begin
                r_slot <= '0;
                r_idx  <= (r_idx == 2'd3) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_slot <= r_slot + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssd_scan_scheduler.sv
// Four-digit display scan controller: picks one of four 16-bit sources,
// snapshots it once per frame and drives anodes/nibble with blanking dead-time.
module ssd_scan_scheduler
    import ssd_scan_scheduler_pkg::*;
#(
    parameter int SCAN_DIV      = 200000,
    parameter int BLANK_CYCLES  = 1000,
    parameter int ROTATE_FRAMES = 250
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [15:0] i_pc_value,
    input  logic [15:0] i_reg_value,
    input  logic [15:0] i_alu_value,
    input  logic [15:0] i_aux_value,
    input  logic [3:0]  i_src_valid,
    input  logic        i_sel_step,
    input  logic        i_auto_rotate,
    output logic [3:0]  o_anodes,
    output logic [3:0]  o_digit_q,
    output logic [1:0]  o_cur_src,
    output logic        o_frame_start
);

    localparam int            RW       = (ROTATE_FRAMES > 1) ? $clog2(ROTATE_FRAMES) : 1;
    localparam logic [RW-1:0] ROT_LAST = RW'(ROTATE_FRAMES - 1);

    idx_t          w_idx;
    logic          w_boundary;
    logic          w_blank_phase;
    src_t          w_pend_step;
    src_t          w_res;
    logic          w_any;
    logic          w_rot_hit;
    logic [15:0]   w_src_val;
    logic [15:0]   w_snap_next;

    logic [3:0]    r_anodes;
    logic [3:0]    r_digit;
    src_t          r_cur;
    src_t          r_pend;
    logic [RW-1:0] r_rot;
    logic [15:0]   r_snap;
    logic          r_blank;

    ssd_scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .o_idx         (w_idx),
        .o_boundary    (w_boundary),
        .o_blank       (w_blank_phase),
        .o_frame_start (o_frame_start)
    );

    // A step landing on the boundary cycle is folded in before resolution.
    assign w_any       = |i_src_valid;
    assign w_pend_step = i_sel_step ? next_valid(r_pend, i_src_valid) : r_pend;
    assign w_res       = i_src_valid[w_pend_step] ? w_pend_step
                                                  : next_valid(w_pend_step, i_src_valid);
    assign w_rot_hit   = w_boundary && i_auto_rotate && !i_sel_step && (r_rot == ROT_LAST);
    assign w_snap_next = (w_boundary && w_any) ? w_src_val : r_snap;

    always_comb begin
        w_src_val = i_pc_value;
        case (w_res)
            SRC_REG: w_src_val = i_reg_value;
            SRC_ALU: w_src_val = i_alu_value;
            SRC_AUX: w_src_val = i_aux_value;
            default: w_src_val = i_pc_value;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_anodes <= AN_OFF;
            r_digit  <= 4'd0;
            r_cur    <= SRC_PC;
            r_pend   <= SRC_PC;
            r_rot    <= '0;
            r_snap   <= '0;
            r_blank  <= 1'b0;
        end else begin
            if (w_blank_phase) r_digit <= digit_nibble(w_snap_next, w_idx);
            r_anodes <= (w_blank_phase || r_blank) ? AN_OFF : anode_pattern(w_idx);

            if (w_boundary) begin
                r_snap <= w_snap_next;
                if (w_any) begin
                    r_cur   <= w_res;
                    r_blank <= 1'b0;
                    // Rotation takes effect at the following boundary.
                    r_pend  <= w_rot_hit ? next_valid(w_res, i_src_valid) : w_res;
                end else begin
                    r_blank <= 1'b1;
                    r_pend  <= w_pend_step;
                end
            end else begin
                r_pend <= w_pend_step;
            end

            if (i_sel_step)
                r_rot <= '0;
            else if (w_boundary && i_auto_rotate)
                r_rot <= (r_rot == ROT_LAST) ? '0 : r_rot + 1'b1;
        end
    end

    assign o_anodes  = r_anodes;
    assign o_digit_q = r_digit;
    assign o_cur_src = r_cur;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Directed bench for ssd_scan_scheduler with SCAN_DIV=8, BLANK_CYCLES=2,
// ROTATE_FRAMES=2; cycle n is sampled 1 time unit after the n-th edge after release.
module tb_ssd_scan_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] pc_v, reg_v, alu_v, aux_v;
    logic [3:0]  valid;
    logic        step;
    logic        auto_r;
    logic [3:0]  anodes;
    logic [3:0]  digit;
    logic [1:0]  cur;
    logic        fs;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ssd_scan_scheduler #(
        .SCAN_DIV      (8),
        .BLANK_CYCLES  (2),
        .ROTATE_FRAMES (2)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_pc_value    (pc_v),
        .i_reg_value   (reg_v),
        .i_alu_value   (alu_v),
        .i_aux_value   (aux_v),
        .i_src_valid   (valid),
        .i_sel_step    (step),
        .i_auto_rotate (auto_r),
        .o_anodes      (anodes),
        .o_digit_q     (digit),
        .o_cur_src     (cur),
        .o_frame_start (fs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (anodes !== 4'b1111 || fs !== 1'b0 || digit !== 4'd0 || cur !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: anodes=%b fs=%b digit=%h cur=%0d, want 1111 0 0 0",
                     anodes, fs, digit, cur);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        int        tc[5] = '{2, 8, 10, 18, 26};
        logic [3:0] ta[5] = '{4'b0111, 4'b1111, 4'b1011, 4'b1101, 4'b1110};
        logic [3:0] td[5] = '{4'h1, 4'h2, 4'h2, 4'h3, 4'h4};
        pc_v = 16'h1234;
        do_reset();
        checks++;
        if (fs !== 1'b1 || digit !== 4'h1 || anodes !== 4'b1111) begin
            errors++;
            $display("FAIL first_boundary: fs=%b digit=%h anodes=%b, want 1 1 1111", fs, digit, anodes);
        end
        run_to(1);
        checks++;
        if (fs !== 1'b0) begin
            errors++;
            $display("FAIL fs_one_cycle: fs=%b want 0", fs);
        end
        for (int i = 0; i < 5; i++) begin
            run_to(tc[i]);
            checks++;
            if (anodes !== ta[i] || digit !== td[i]) begin
                errors++;
                $display("FAIL scan_c%0d: anodes=%b digit=%h, want %b %h", tc[i], anodes, digit, ta[i], td[i]);
            end
        end
        run_to(31);
        checks++;
        if (fs !== 1'b0) begin
            errors++;
            $display("FAIL fs_c31: fs=%b want 0", fs);
        end
        run_to(32);
        checks++;
        if (fs !== 1'b1) begin
            errors++;
            $display("FAIL fs_c32: fs=%b want 1", fs);
        end
    endtask

    task automatic test_snapshot();
        int        tc[7] = '{10, 18, 26, 34, 42, 50, 58};
        logic [3:0] td[7] = '{4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};
        pc_v = 16'h1234;
        do_reset();
        run_to(5);
        pc_v = 16'hABCD;
        for (int i = 0; i < 7; i++) begin
            run_to(tc[i]);
            checks++;
            if (digit !== td[i]) begin
                errors++;
                $display("FAIL snapshot_c%0d: digit=%h want %h", tc[i], digit, td[i]);
            end
        end
        pc_v = 16'h1234;
    endtask

    task automatic test_sel_step();
        int        tc[4] = '{34, 42, 50, 58};
        logic [3:0] td[4] = '{4'h0, 4'h0, 4'hF, 4'hF};
        do_reset();
        run_to(9);
        step = 1'b1;
        run_to(10);
        step = 1'b0;
        run_to(31);
        checks++;
        if (cur !== 2'd0) begin
            errors++;
            $display("FAIL step_hold_c31: cur=%0d want 0", cur);
        end
        run_to(32);
        checks++;
        if (cur !== 2'd1) begin
            errors++;
            $display("FAIL step_commit_c32: cur=%0d want 1", cur);
        end
        for (int i = 0; i < 4; i++) begin
            run_to(tc[i]);
            checks++;
            if (digit !== td[i]) begin
                errors++;
                $display("FAIL step_digit_c%0d: digit=%h want %h", tc[i], digit, td[i]);
            end
        end
    endtask

    task automatic test_valid_mask();
        int bad = 0;
        do_reset();
        valid = 4'b1001;
        run_to(3);
        step = 1'b1;
        run_to(4);
        step = 1'b0;
        run_to(31);
        checks++;
        if (cur !== 2'd0) begin
            errors++;
            $display("FAIL mask_hold_c31: cur=%0d want 0", cur);
        end
        run_to(32);
        checks++;
        if (cur !== 2'd3) begin
            errors++;
            $display("FAIL mask_skip_c32: cur=%0d want 3", cur);
        end
        run_to(34);
        checks++;
        if (digit !== 4'hC || anodes !== 4'b0111) begin
            errors++;
            $display("FAIL mask_aux_digit: digit=%h anodes=%b, want c 0111", digit, anodes);
        end
        run_to(40);
        valid = 4'b0000;
        for (int c = 64; c < 96; c++) begin
            run_to(c);
            if (anodes !== 4'b1111) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL none_valid_dark: %0d cycles lit, want 0", bad);
        end
        run_to(96);
        checks++;
        if (fs !== 1'b1 || cur !== 2'd3) begin
            errors++;
            $display("FAIL none_valid_fs: fs=%b cur=%0d, want 1 3", fs, cur);
        end
        run_to(100);
        valid = 4'b1111;
        run_to(130);
        checks++;
        if (cur !== 2'd3 || anodes !== 4'b0111 || digit !== 4'hC) begin
            errors++;
            $display("FAIL relit: cur=%0d anodes=%b digit=%h, want 3 0111 c", cur, anodes, digit);
        end
    endtask

    task automatic test_auto_rotate();
        int        tc[6]  = '{63, 64, 127, 128, 191, 192};
        logic [1:0] ts[6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3};
        int        uc[5]  = '{95, 96, 128, 159, 160};
        logic [1:0] us[5] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
        auto_r = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_to(tc[i]);
            checks++;
            if (cur !== ts[i]) begin
                errors++;
                $display("FAIL rotate_c%0d: cur=%0d want %0d", tc[i], cur, ts[i]);
            end
        end
        do_reset();
        run_to(69);
        step = 1'b1;
        run_to(70);
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run_to(uc[i]);
            checks++;
            if (cur !== us[i]) begin
                errors++;
                $display("FAIL rotate_step_c%0d: cur=%0d want %0d", uc[i], cur, us[i]);
            end
        end
        auto_r = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        run_to(3);
        step = 1'b1;
        run_to(4);
        step = 1'b0;
        run_to(5);
        step = 1'b1;
        run_to(6);
        step = 1'b0;
        run_to(32);
        checks++;
        if (cur !== 2'd2) begin
            errors++;
            $display("FAIL two_steps: cur=%0d want 2", cur);
        end
        run_to(63);
        step = 1'b1;
        run_to(64);
        step = 1'b0;
        checks++;
        if (cur !== 2'd3 || fs !== 1'b1) begin
            errors++;
            $display("FAIL step_on_boundary: cur=%0d fs=%b, want 3 1", cur, fs);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_to(13);
        checks++;
        if (anodes !== 4'b1011 || digit !== 4'h2) begin
            errors++;
            $display("FAIL pre_reset_c13: anodes=%b digit=%h, want 1011 2", anodes, digit);
        end
        rst = 1'b1;
        run_to(14);
        checks++;
        if (anodes !== 4'b1111 || digit !== 4'h0 || cur !== 2'd0 || fs !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_c14: anodes=%b digit=%h cur=%0d fs=%b, want 1111 0 0 0",
                     anodes, digit, cur, fs);
        end
        rst = 1'b0;
        run_to(15);
        checks++;
        if (fs !== 1'b1 || digit !== 4'h1) begin
            errors++;
            $display("FAIL restart_c15: fs=%b digit=%h, want 1 1", fs, digit);
        end
    endtask

    initial begin
        rst    = 1'b1;
        pc_v   = 16'h1234;
        reg_v  = 16'h00FF;
        alu_v  = 16'h5678;
        aux_v  = 16'hC3E1;
        valid  = 4'b1111;
        step   = 1'b0;
        auto_r = 1'b0;
        test_reset();
        test_snapshot();
        test_sel_step();
        test_valid_mask();
        test_auto_rotate();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
